// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and data-memory signals of the load/store unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // master: the load/store unit itself, initiator of the memory port
    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    // slave: execute stage plus data memory
    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit; sub-word stores via read-modify-write
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses become errors.
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    load_store_unit_if.master    bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        err_q, err_d;

    logic        accept;
    logic [1:0]  req_size;
    logic        funct3_ok;
    logic        out_of_range;
    logic        dec_err;
    logic [31:0] dec_addr;
    logic [31:0] merged_word;

    function automatic logic [31:0] load_extend(input logic [31:0] w,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'd0, b};
            3'd5:    r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic [15:0] d,
                                                input logic [1:0]  off,
                                                input logic        half);
        logic [31:0] r;
        r = w;
        if (half) begin
            if (off[1]) r[31:16] = d;
            else        r[15:0]  = d;
        end else begin
            case (off)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    assign accept   = bus.req_valid && (state_q == S_IDLE);
    assign req_size = bus.req_funct3[1:0];

    always_comb begin
        funct3_ok = 1'b0;
        if (bus.req_we) begin
            funct3_ok = (bus.req_funct3 == 3'd0) || (bus.req_funct3 == 3'd1) ||
                        (bus.req_funct3 == 3'd2);
        end else begin
            funct3_ok = (bus.req_funct3 == 3'd0) || (bus.req_funct3 == 3'd1) ||
                        (bus.req_funct3 == 3'd2) || (bus.req_funct3 == 3'd4) ||
                        (bus.req_funct3 == 3'd5);
        end
    end

    assign out_of_range = {2'b00, bus.req_addr[31:2]} >= MEM_WORDS_W;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((req_size == 2'd1) && bus.req_addr[0]) ||
                        ((req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
    assign dec_err    = !funct3_ok || out_of_range || misaligned;
    assign dec_addr   = bus.req_addr;
`else
    // Offset bits below the access size are dropped so the access lands on its natural boundary
    always_comb begin
        dec_addr = bus.req_addr;
        case (req_size)
            2'd1:    dec_addr = {bus.req_addr[31:1], 1'b0};
            2'd2:    dec_addr = {bus.req_addr[31:2], 2'b00};
            default: dec_addr = bus.req_addr;
        endcase
    end
    assign dec_err = !funct3_ok || out_of_range;
`endif

    assign merged_word = store_merge(word_q, wdata_q[15:0], addr_q[1:0], funct3_q[0]);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        resp_data_d = resp_data_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d        = bus.req_we;
                    funct3_d    = bus.req_funct3;
                    addr_d      = dec_addr;
                    wdata_d     = bus.req_wdata;
                    resp_data_d = 32'd0;
                    err_d       = dec_err;
                    if (dec_err)
                        state_d = S_RESP;
                    else if (bus.req_we && (req_size == 2'd2))
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                if (we_q) begin
                    word_d  = bus.mem_rdata;
                    state_d = S_WRITE;
                end else begin
                    resp_data_d = load_extend(bus.mem_rdata, addr_q[1:0], funct3_q);
                    state_d     = S_RESP;
                end
            end
            S_WRITE: begin
                state_d = S_RESP;
            end
            default: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            word_q      <= 32'd0;
            resp_data_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
        end
    end

    // Strobes decode straight from state so an asynchronous reset kills them within the cycle
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_err   = (state_q == S_RESP) && err_q;
    assign bus.resp_data  = (state_q == S_RESP) ? resp_data_q : 32'd0;
    assign bus.mem_read   = (state_q == S_READ);
    assign bus.mem_write  = (state_q == S_WRITE);
    assign bus.mem_addr   = ((state_q == S_READ) || (state_q == S_WRITE)) ?
                            {2'b00, addr_q[31:2]} : 32'd0;
    assign bus.mem_wdata  = (state_q != S_WRITE)   ? 32'd0 :
                            (funct3_q[1:0] == 2'd2) ? wdata_q : merged_word;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port. It accepts one load or store request at a time from the execute stage and drives the word-addressed data memory's read/write strobes, word index and write data. Loads are byte-, halfword- or word-sized with sign or zero extension. Sub-word stores are done as a read-modify-write so that a word-only memory supports SB/SH. It sits between the core's execute stage and the data memory; the memory returns read data combinationally while its read strobe is high.

## Interface
- MEM_WORDS, default 64: number of 32-bit words in the attached memory. A request whose word index is MEM_WORDS or greater is out of range.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  output  1  response present; held until accepted.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  32  extended load result; 0 for stores and errors.
- resp_err  output  1  request was rejected with no memory side effect.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe, sampled by memory on the rising edge.
- mem_addr  output  32  word index, equal to the latched req_addr[31:2].
- mem_wdata  output  32  word to write.
- mem_rdata  input  32  combinational read data from memory.

## Operation
- States: IDLE, READ, WRITE, RESP.
- Request acceptance: the handshake req_valid & req_ready in IDLE latches we, funct3, addr and wdata.
- Decode at acceptance:
  - err = illegal funct3 (load 3/6/7, store 3-7), or word index ≥ MEM_WORDS, or misalignment (see Configuration).
  - err → RESP with resp_err=1.
  - load → READ.
  - SW → WRITE.
  - SB/SH → READ.
- READ:
  - mem_read=1.
  - mem_rdata is captured into the internal word register at the closing edge.
  - Next state: load → RESP; SB/SH → WRITE.
- WRITE:
  - mem_write=1 for exactly one cycle.
  - mem_wdata = req_wdata for SW.
  - For SB/SH, mem_wdata = the captured word with the selected lane replaced.
  - Next state: RESP.
- Lanes are little-endian. Byte k = bits [8k+7:8k], with k = addr[1:0]. Halfword h = bits [16h+15:16h], with h = addr[1].
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- RESP:
  - resp_valid=1; resp_data and resp_err are stable.
  - resp_valid & resp_ready → IDLE.
  - Otherwise hold all response fields.
- mem_read and mem_write are never high together, and both are 0 outside READ/WRITE.
- mem_addr and mem_wdata are 0 in IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_data=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- Reset is asynchronous. An assertion in any state forces IDLE and drops mem_read/mem_write immediately, so no write is issued. Release takes effect at the next edge.
- Latency counts from the acceptance edge (cycle 0) to the first resp_valid cycle:
  - load: 2 (READ, then RESP)
  - SW: 2 (WRITE, then RESP)
  - SB/SH: 3 (READ, WRITE, RESP)
  - error: 1
- Back-to-back: the fastest request rate is one every 3 cycles for word ops (IDLE, op, RESP). The next request can be accepted in the cycle after resp is accepted.
- A request presented while not in IDLE is not accepted and must be held by the source.

## Configuration
- LSU_MISALIGN_TRAP_EN:
  - Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]≠0, is an error (resp_err=1, latency 1, no memory strobe).
  - Undefined: misaligned addresses are silently aligned down, with the offset bits for the access size forced to 0, and the access proceeds normally.
- Illegal funct3 and out-of-range errors apply in both builds.

## Test plan
- SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 → mem_write one cycle with mem_addr=4; load resp_data=0xDEADBEEF at latency 2, resp_err=0.
- Word 4 = 0x11223344. SB addr=0x12 wdata=0xAA → READ then WRITE with mem_wdata=0x11AA3344; LB addr=0x12 → 0xFFFFFFAA; LBU → 0x000000AA.
- Word 5 = 0x8001_7FFF. LH addr=0x14 → 0x00007FFF; LH addr=0x16 → 0xFFFF8001; LHU addr=0x16 → 0x00008001.
- LW addr=0x102 with the macro defined → resp_err=1 at latency 1 and no strobes. Without the macro → reads word 0x40 >> out of range → resp_err=1. LW addr=0x100 (index 64) → resp_err=1 in both builds.
- Hold resp_ready=0 for 5 cycles on a load → resp_valid and resp_data stable and req_ready=0 throughout; IDLE the cycle after resp_ready=1.
- Assert reset during the WRITE state of an SB → mem_write falls immediately, the memory word is unchanged, and req_ready=1 after release.
